// File: rtl/rbm_prob_sampler.sv
// Stochastic-neuron sampler: packs N LFSR bits per cycle into W-bit uniform words
// and draws one binary sample (rand_word < prob) per accepted probability.
module rbm_prob_sampler #(
    parameter int N = 1,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] rand_in,
    input  logic [W-1:0] prob_in,
    input  logic         prob_valid,
    output logic         prob_ready,
    output logic         sample_out,
    output logic         sample_valid,
    input  logic         sample_ready,
    output logic [W-1:0] rand_word,
    output logic [15:0]  words_dropped
);

    localparam int FILL = W / N;
    localparam int CW   = (FILL > 1) ? $clog2(FILL) : 1;
    localparam int SW   = (W > N) ? (W - N) : 1;

    generate
        if ((N < 1) || (W < N) || ((W % N) != 0)) begin : g_bad_param
            $error("rbm_prob_sampler: W must be a non-zero multiple of N");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OUT} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   pk_shift_q, pk_shift_d;
    logic [CW-1:0]   pk_cnt_q, pk_cnt_d;
    logic [W-1:0]    wbuf_q, wbuf_d;
    logic            wbuf_vld_q, wbuf_vld_d;
    logic [W-1:0]    prob_q, prob_d;
    logic            sample_out_q, sample_out_d;
    logic            sample_valid_q, sample_valid_d;
    logic [W-1:0]    rand_word_q, rand_word_d;
    logic [15:0]     words_dropped_q, words_dropped_d;

    logic [W-1:0]    pk_word;
    logic            word_done;
    logic            consume;

    // Only the low W-N bits of the shifter are ever read back, so only those are stored.
    generate
        if (W > N) begin : g_pack_wide
            assign pk_word = {pk_shift_q, rand_in};
        end else begin : g_pack_narrow
            assign pk_word = rand_in;
        end
    endgenerate

    assign word_done = (pk_cnt_q == CW'(FILL - 1));

    always_comb begin
        state_d         = state_q;
        prob_d          = prob_q;
        sample_out_d    = sample_out_q;
        sample_valid_d  = sample_valid_q;
        rand_word_d     = rand_word_q;
        prob_ready      = 1'b0;
        consume         = 1'b0;

        case (state_q)
            S_IDLE: begin
                prob_ready = 1'b1;
                if (prob_valid) begin
                    prob_d  = prob_in;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wbuf_vld_q) begin
                    consume        = 1'b1;
                    sample_out_d   = (wbuf_q < prob_q);
                    rand_word_d    = wbuf_q;
                    sample_valid_d = 1'b1;
                    state_d        = S_OUT;
                end
            end
            S_OUT: begin
                prob_ready = sample_ready;
                if (sample_ready) begin
                    sample_valid_d = 1'b0;
                    if (prob_valid) begin
                        prob_d  = prob_in;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        pk_shift_d      = pk_word[SW-1:0];
        pk_cnt_d        = word_done ? '0 : pk_cnt_q + CW'(1);
        wbuf_d          = wbuf_q;
        wbuf_vld_d      = consume ? 1'b0 : wbuf_vld_q;
        words_dropped_d = words_dropped_q;

        // A word consumed this cycle frees the buffer for the word completing now.
        if (word_done) begin
            if (!wbuf_vld_q || consume) begin
                wbuf_d     = pk_word;
                wbuf_vld_d = 1'b1;
            end else if (words_dropped_q != 16'hFFFF) begin
                words_dropped_d = words_dropped_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            pk_shift_q      <= '0;
            pk_cnt_q        <= '0;
            wbuf_q          <= '0;
            wbuf_vld_q      <= 1'b0;
            prob_q          <= '0;
            sample_out_q    <= 1'b0;
            sample_valid_q  <= 1'b0;
            rand_word_q     <= '0;
            words_dropped_q <= '0;
        end else begin
            state_q         <= state_d;
            pk_shift_q      <= pk_shift_d;
            pk_cnt_q        <= pk_cnt_d;
            wbuf_q          <= wbuf_d;
            wbuf_vld_q      <= wbuf_vld_d;
            prob_q          <= prob_d;
            sample_out_q    <= sample_out_d;
            sample_valid_q  <= sample_valid_d;
            rand_word_q     <= rand_word_d;
            words_dropped_q <= words_dropped_d;
        end
    end

    assign sample_out    = sample_out_q;
    assign sample_valid  = sample_valid_q;
    assign rand_word     = rand_word_q;
    assign words_dropped = words_dropped_q;

endmodule

// File: tb/tb_rbm_prob_sampler.sv
// Randomized bench for rbm_prob_sampler (N=4, W=8) against a transaction-level model:
// a one-deep word buffer, a pending probability and an outstanding sample.
module tb_rbm_prob_sampler;

    localparam int N = 4;
    localparam int W = 8;
    localparam int FILL = W / N;

    logic         clk;
    logic         rst;
    logic [N-1:0] rand_in;
    logic [W-1:0] prob_in;
    logic         prob_valid;
    logic         prob_ready;
    logic         sample_out;
    logic         sample_valid;
    logic         sample_ready;
    logic [W-1:0] rand_word;
    logic [15:0]  words_dropped;

    rbm_prob_sampler #(.N(N), .W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .rand_in       (rand_in),
        .prob_in       (prob_in),
        .prob_valid    (prob_valid),
        .prob_ready    (prob_ready),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .rand_word     (rand_word),
        .words_dropped (words_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit         m_pend;
    int         m_prob;
    bit         m_out;
    bit         m_sample;
    int         m_rword;
    int         m_drop;
    int         m_buf;
    bit         m_buf_v;
    int         m_part;
    int         m_cnt;

    logic [15:0] lfsr;

    task automatic model_reset();
        m_pend = 0; m_prob = 0; m_out = 0; m_sample = 0; m_rword = 0;
        m_drop = 0; m_buf = 0; m_buf_v = 0; m_part = 0; m_cnt = 0;
    endtask

    function automatic logic [3:0] rnd4();
        return 4'($urandom);
    endfunction

    function automatic logic [7:0] rnd8();
        return 8'($urandom);
    endfunction

    // Drive one cycle's inputs at a falling edge, check outputs, advance the model
    // across the next rising edge, and return at the following falling edge.
    task automatic step(input logic [3:0] r, input logic pv, input logic [7:0] p, input logic sr);
        bit exp_ready;
        rand_in = r; prob_valid = pv; prob_in = p; sample_ready = sr;
        #1;
        exp_ready = !m_pend && (!m_out || sr);
        check_eq("prob_ready", {31'd0, prob_ready}, {31'd0, exp_ready});
        check_eq("sample_valid", {31'd0, sample_valid}, {31'd0, m_out});
        check_eq("sample_out", {31'd0, sample_out}, {31'd0, m_sample});
        check_eq("rand_word", {24'd0, rand_word}, m_rword);
        check_eq("words_dropped", {16'd0, words_dropped}, m_drop);

        if (m_out && sr) m_out = 0;
        if (m_pend && m_buf_v) begin
            m_out    = 1;
            m_sample = (m_buf < m_prob);
            m_rword  = m_buf;
            m_buf_v  = 0;
            m_pend   = 0;
        end
        m_part = (m_part * 16 + int'(r)) % 256;
        m_cnt++;
        if (m_cnt == FILL) begin
            m_cnt = 0;
            if (!m_buf_v) begin
                m_buf   = m_part;
                m_buf_v = 1;
            end else if (m_drop < 65535) begin
                m_drop++;
            end
        end
        if (exp_ready && pv) begin
            m_pend = 1;
            m_prob = int'(p);
        end
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check_eq("rst_sample_valid", {31'd0, sample_valid}, 0);
        check_eq("rst_sample_out", {31'd0, sample_out}, 0);
        check_eq("rst_rand_word", {24'd0, rand_word}, 0);
        check_eq("rst_words_dropped", {16'd0, words_dropped}, 0);
        check_eq("rst_prob_ready", {31'd0, prob_ready}, 1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input logic [3:0] r, input bit rnd);
        for (int k = 0; k < 12 && sample_valid !== 1'b1; k++)
            step(rnd ? rnd4() : r, 1'b0, 8'h00, 1'b0);
        check_eq("wait_valid", {31'd0, sample_valid}, 1);
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        logic [15:0] t;
        t = s;
        for (int b = 0; b < 4; b++) t = {t[14:0], t[15] ^ t[13] ^ t[12] ^ t[10]};
        return t;
    endfunction

    int  draws;
    int  ones;
    bit  held_s;
    int  held_w;

    initial begin
        rst = 1'b1;
        rand_in = '0; prob_in = '0; prob_valid = 1'b0; sample_ready = 1'b0;
        lfsr = 16'hACE1;
        model_reset();
        @(negedge clk);
        do_reset();

        // Held rand 3: words are 8'h33; strict compare at the boundary
        repeat (3) step(4'h3, 1'b0, 8'h00, 1'b0);
        step(4'h3, 1'b1, 8'h34, 1'b0);
        wait_valid(4'h3, 0);
        check_eq("t1_rword", {24'd0, rand_word}, 32'h33);
        check_eq("t1_hit", {31'd0, sample_out}, 1);
        step(4'h3, 1'b1, 8'h33, 1'b1);
        wait_valid(4'h3, 0);
        check_eq("t1_rword_eq", {24'd0, rand_word}, 32'h33);
        check_eq("t1_strict", {31'd0, sample_out}, 0);
        step(4'h3, 1'b0, 8'h00, 1'b1);

        // Packing order and dropping
        do_reset();
        step(4'h1, 1'b0, 8'h00, 1'b0);
        step(4'h2, 1'b0, 8'h00, 1'b0);
        step(4'h3, 1'b0, 8'h00, 1'b0);
        step(4'h4, 1'b0, 8'h00, 1'b0);
        check_eq("t2_drop", {16'd0, words_dropped}, 1);
        step(4'h5, 1'b1, 8'hFF, 1'b0);
        wait_valid(4'h6, 0);
        check_eq("t2_rword", {24'd0, rand_word}, 32'h12);
        check_eq("t2_hit", {31'd0, sample_out}, 1);
        check_eq("t2_drop_after", {16'd0, words_dropped}, 1);
        step(4'h0, 1'b0, 8'h00, 1'b1);

        // Backpressure then back-to-back accept
        step(rnd4(), 1'b1, 8'h80, 1'b0);
        wait_valid(4'h0, 1);
        held_s = m_sample;
        held_w = m_rword;
        for (int k = 0; k < 5; k++) begin
            step(rnd4(), 1'b1, rnd8(), 1'b0);
            check_eq("bp_ready", {31'd0, prob_ready}, 0);
            check_eq("bp_valid", {31'd0, sample_valid}, 1);
            check_eq("bp_sample", {31'd0, sample_out}, {31'd0, held_s});
            check_eq("bp_rword", {24'd0, rand_word}, held_w);
        end
        step(rnd4(), 1'b1, 8'h40, 1'b1);
        check_eq("b2b_valid_low", {31'd0, sample_valid}, 0);
        check_eq("b2b_in_wait", {31'd0, prob_ready}, 0);
        wait_valid(4'h0, 1);
        step(rnd4(), 1'b0, 8'h00, 1'b1);

        // prob = 0 never fires
        draws = 0;
        for (int k = 0; k < 400 && draws < 32; k++) begin
            if (m_out) begin
                check_eq("p0_sample", {31'd0, sample_out}, 0);
                draws++;
            end
            step(rnd4(), 1'b1, 8'h00, 1'b1);
        end
        check_eq("p0_draws", draws, 32);
        for (int k = 0; k < 8 && (m_out || m_pend); k++) step(rnd4(), 1'b0, 8'h00, 1'b1);

        // prob = FF against an all-ones word
        do_reset();
        repeat (2) step(4'hF, 1'b0, 8'h00, 1'b0);
        step(4'hF, 1'b1, 8'hFF, 1'b0);
        wait_valid(4'hF, 0);
        check_eq("pff_rword", {24'd0, rand_word}, 32'hFF);
        check_eq("pff_sample", {31'd0, sample_out}, 0);
        step(4'hF, 1'b0, 8'h00, 1'b1);

        // Reset in WAIT with a half-packed word
        do_reset();
        step(4'h7, 1'b1, 8'h40, 1'b0);
        check_eq("t5_in_wait", {31'd0, prob_ready}, 0);
        do_reset();
        step(4'h9, 1'b0, 8'h00, 1'b0);
        step(4'h6, 1'b0, 8'h00, 1'b0);
        step(4'h0, 1'b1, 8'hFF, 1'b0);
        wait_valid(4'h0, 0);
        check_eq("t5_rword", {24'd0, rand_word}, 32'h96);
        step(4'h0, 1'b0, 8'h00, 1'b1);

        // LFSR-driven, prob = 1/2
        do_reset();
        draws = 0;
        ones  = 0;
        for (int k = 0; k < 8000 && draws < 1024; k++) begin
            if (m_out) begin
                draws++;
                if (sample_out === 1'b1) ones++;
            end
            lfsr = lfsr_adv(lfsr);
            step(lfsr[3:0], 1'b1, 8'h80, 1'b1);
        end
        check_eq("lfsr_draws", draws, 1024);
        check_eq("lfsr_ones_in_range", {31'd0, (ones >= 448 && ones <= 576)}, 1);

        // Fully random traffic
        for (int k = 0; k < 2000; k++)
            step(rnd4(), 1'($urandom), rnd8(), 1'($urandom));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rbm_prob_sampler.md
Name: rbm_prob_sampler

Overview:
- Stochastic-neuron sampler that sits directly downstream of the lookahead LFSR.
- Packs the LFSR's N fresh random bits per cycle into W-bit uniform random words.
- Draws one binary sample per accepted probability: sample = (rand_word < prob).
- Feeds the RBM's hidden/visible spin update logic over a valid/ready handshake.

Parameters:
- N, 1: random bits arriving per cycle; must match the LFSR's output width.
- W, 8: probability and random-word width in bits. Legal values: W >= N and W % N == 0; elaboration fails otherwise.
- FILL, W/N (derived localparam, not overridable): cycles needed to build one random word.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state immediately.
- rand_in  in  N  free-running random bits from the LFSR; new value every cycle.
- prob_in  in  W  unsigned firing probability, scaled so that 2^W represents 1.0.
- prob_valid  in  1  prob_in is valid.
- prob_ready  out  1  sampler accepts prob_in this cycle.
- sample_out  out  1  drawn binary sample.
- sample_valid  out  1  sample_out is valid.
- sample_ready  in  1  consumer accepts the sample.
- rand_word  out  W  word used for the most recent comparison (debug).
- words_dropped  out  16  count of completed words discarded because the buffer was full; saturates at 16'hFFFF.

Behaviour:
- Reset values: state=IDLE, pk_shift=0, pk_cnt=0, wbuf=0, wbuf_vld=0, prob_q=0, sample_out=0, sample_valid=0, rand_word=0, words_dropped=0.
- Packer (runs every cycle, independent of the FSM):
  - pk_shift <= {pk_shift[W-N-1:0], rand_in}. When W==N, pk_shift <= rand_in.
  - pk_cnt counts 0..FILL-1 and wraps to 0.
  - When pk_cnt==FILL-1, the completed word is {pk_shift[W-N-1:0], rand_in}. The first rand_in of a word ends up in the MSBs.
  - Load the completed word into wbuf and set wbuf_vld if wbuf_vld==0 or wbuf is consumed that same cycle.
  - Otherwise drop the word and increment words_dropped (saturating).
- FSM states: IDLE, WAIT, OUT.
- IDLE:
  - prob_ready=1.
  - On prob_valid: prob_q<=prob_in, go to WAIT.
- WAIT:
  - prob_ready=0.
  - When wbuf_vld: consume wbuf (clear wbuf_vld unless reloaded the same cycle).
  - Same edge: sample_out <= (wbuf < prob_q) as an unsigned strict compare; rand_word<=wbuf; sample_valid<=1; go to OUT.
  - If wbuf_vld==0, stay in WAIT.
- OUT:
  - sample_valid=1; sample_out and rand_word are held stable.
  - prob_ready = sample_ready.
  - On sample_ready && prob_valid: latch prob_q, clear sample_valid, go to WAIT (back-to-back operation).
  - On sample_ready && !prob_valid: clear sample_valid, go to IDLE.
  - Without sample_ready: hold.
- Latency: prob accept edge to sample_valid high is 1 cycle if wbuf_vld was already set; otherwise it waits for the next completed word, at most FILL+1 cycles.
- Each random word is used exactly once; no word is compared twice.
- Boundaries:
  - prob=0 always gives 0.
  - prob={W{1'b1}} gives 1 unless the word is all ones.
  - The FSM never accepts a new prob while sample_valid is held without sample_ready.
  - rst asserted in any state returns everything to reset values asynchronously. A partially packed word is lost; packing restarts with pk_cnt=0 after release.

Test Plan:
- N=4, W=8, rand_in held at 4'h3, prob_in=8'h34 -> rand_word=8'h33, sample_out=1. Repeat with prob_in=8'h33 -> sample_out=0 (strict compare).
- N=4, W=8, rand_in sequence 4'h1,4'h2,4'h3,4'h4 after reset, no prob offered -> wbuf=8'h12, 8'h34 dropped, words_dropped=1. Then prob_in=8'hFF -> rand_word=8'h12, sample_out=1.
- Backpressure: sample_ready low for 5 cycles in OUT -> sample_valid, sample_out and rand_word stable, prob_ready=0. sample_ready and prob_valid both high on the same cycle -> immediate return to WAIT, no idle cycle.
- prob_in=8'h00 for 32 draws -> all samples 0. prob_in=8'hFF with rand_in held at 4'hF -> sample_out=0.
- Assert rst while in WAIT with a half-packed word -> outputs return to reset values immediately. After release, the first completed word is formed from the post-reset rand_in only.
- Connect the real LFSR (N=4, W=8), prob_in=8'h80, 1024 samples -> count of ones within 512±64, and words_dropped never exceeds 16'hFFFF.
